// File: rtl/mult_pkg.sv
// Shared state type and sizing helper for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } mult_state_e;

   // Counter must be able to hold the value ITERS itself, not just ITERS-1.
   function automatic int iter_cnt_w(input int b_w, input int step);
      return $clog2(b_w / step + 1);
   endfunction

endpackage

// File: rtl/mult_sat.sv
// Result stage: shifts the full-width product right by SHIFT and clamps it
// into the P_W output range, flagging when the clamp was applied.
module mult_sat
   import mult_pkg::*;
#(
   parameter int FW       = 22,
   parameter int P_W      = 14,
   parameter int SHIFT    = 8,
   parameter bit A_SIGNED = 1'b0
) (
   input  logic [FW-1:0]  full_i,
   output logic [P_W-1:0] prod_o,
   output logic           ovf_o
);

   logic [FW-1:0] shifted;

   always_comb begin
      if (A_SIGNED) begin
         shifted = $signed(full_i) >>> SHIFT;
      end else begin
         shifted = full_i >> SHIFT;
      end
   end

   generate
      if (P_W < FW) begin : g_clamp
         if (A_SIGNED) begin : g_signed
            // In range exactly when every bit above the output sign bit copies it.
            always_comb begin
               prod_o = shifted[P_W-1:0];
               ovf_o  = 1'b0;
               if (shifted[FW-1:P_W-1] != {(FW-P_W+1){shifted[FW-1]}}) begin
                  ovf_o  = 1'b1;
                  prod_o = shifted[FW-1] ? {1'b1, {(P_W-1){1'b0}}}
                                         : {1'b0, {(P_W-1){1'b1}}};
               end
            end
         end else begin : g_unsigned
            always_comb begin
               prod_o = shifted[P_W-1:0];
               ovf_o  = 1'b0;
               if (shifted[FW-1:P_W] != '0) begin
                  ovf_o  = 1'b1;
                  prod_o = '1;
               end
            end
         end
      end else begin : g_wide
         always_comb begin
            ovf_o  = 1'b0;
            prod_o = A_SIGNED ? P_W'($signed(shifted)) : P_W'(shifted);
         end
      end
   endgenerate

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: consumes STEP bits of B per cycle, then
// shifts and saturates. Define MULT_ROUND_EN for round-half-up before the shift.
module mult_seq
   import mult_pkg::*;
#(
   parameter int A_W      = 14,
   parameter int B_W      = 8,
   parameter int P_W      = 14,
   parameter int SHIFT    = 8,
   parameter int STEP     = 1,
   parameter bit A_SIGNED = 1'b0
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           start_i,
   input  logic           abort_i,
   input  logic [A_W-1:0] op_a_i,
   input  logic [B_W-1:0] op_b_i,
   output logic           ready_o,
   output logic           busy_o,
   output logic           done_o,
   output logic [P_W-1:0] prod_o,
   output logic           ovf_o
);

   localparam int FW    = A_W + B_W;
   localparam int ITERS = B_W / STEP;
   localparam int IW    = iter_cnt_w(B_W, STEP);

`ifdef MULT_ROUND_EN
   localparam int            RSH     = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [FW-1:0] ROUND_C = (SHIFT > 0) ? (FW'(1) << RSH) : '0;
`else
   localparam logic [FW-1:0] ROUND_C = '0;
`endif

   mult_state_e    state_q, state_d;
   logic [FW-1:0]  a_q, a_d;
   logic [FW-1:0]  acc_q, acc_d;
   logic [B_W-1:0] b_q, b_d;
   logic [IW-1:0]  iter_q, iter_d;
   logic [P_W-1:0] prod_q, prod_d;
   logic           ovf_q, ovf_d;
   logic           done_q, done_d;

   logic [FW-1:0]  a_ext;
   logic [FW-1:0]  acc_next;
   logic [P_W-1:0] sat_prod;
   logic           sat_ovf;

   // Two's complement makes the signed case fall out of modulo-2^FW accumulation.
   always_comb begin
      a_ext    = A_SIGNED ? {{B_W{op_a_i[A_W-1]}}, op_a_i} : {{B_W{1'b0}}, op_a_i};
      acc_next = acc_q + a_q * FW'(b_q[STEP-1:0]);
   end

   mult_sat #(
      .FW       (FW),
      .P_W      (P_W),
      .SHIFT    (SHIFT),
      .A_SIGNED (A_SIGNED)
   ) u_sat (
      .full_i (acc_next),
      .prod_o (sat_prod),
      .ovf_o  (sat_ovf)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      iter_d  = iter_q;
      prod_d  = prod_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = ITER;
               a_d     = a_ext;
               b_d     = op_b_i;
               acc_d   = ROUND_C;
               iter_d  = '0;
            end
         end
         ITER: begin
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               a_d    = a_q << STEP;
               b_d    = b_q >> STEP;
               acc_d  = acc_next;
               iter_d = iter_q + IW'(1);
               // The result stage sees the final partial sum on this same edge.
               if (iter_q == IW'(ITERS - 1)) begin
                  state_d = DONE;
                  prod_d  = sat_prod;
                  ovf_d   = sat_ovf;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
         prod_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         iter_q  <= iter_d;
         prod_q  <= prod_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign ready_o = (state_q == IDLE) || (state_q == DONE);
   assign busy_o  = (state_q == ITER);
   assign done_o  = done_q;
   assign prod_o  = prod_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: three configurations (unsigned 14-bit out,
// signed 8-bit out STEP=2, unsigned 8-bit out STEP=2) against an arithmetic model.
module tb_mult_seq;

   localparam int SHIFT = 8;
`ifdef MULT_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef struct {
      int     inst;
      longint p;
      bit     o;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start [3];
   logic        abort [3];
   logic [13:0] op_a  [3];
   logic [7:0]  op_b  [3];
   logic        ready [3];
   logic        busy  [3];
   logic        done  [3];
   logic        ovf   [3];
   logic [13:0] prod_u;
   logic [7:0]  prod_s;
   logic [7:0]  prod_v;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mult_seq #(.A_W(14), .B_W(8), .P_W(14), .SHIFT(SHIFT), .STEP(1), .A_SIGNED(1'b0)) dut_u (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .abort_i(abort[0]),
      .op_a_i(op_a[0]), .op_b_i(op_b[0]), .ready_o(ready[0]), .busy_o(busy[0]),
      .done_o(done[0]), .prod_o(prod_u), .ovf_o(ovf[0]));

   mult_seq #(.A_W(14), .B_W(8), .P_W(8), .SHIFT(SHIFT), .STEP(2), .A_SIGNED(1'b1)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .abort_i(abort[1]),
      .op_a_i(op_a[1]), .op_b_i(op_b[1]), .ready_o(ready[1]), .busy_o(busy[1]),
      .done_o(done[1]), .prod_o(prod_s), .ovf_o(ovf[1]));

   mult_seq #(.A_W(14), .B_W(8), .P_W(8), .SHIFT(SHIFT), .STEP(2), .A_SIGNED(1'b0)) dut_v (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .abort_i(abort[2]),
      .op_a_i(op_a[2]), .op_b_i(op_b[2]), .ready_o(ready[2]), .busy_o(busy[2]),
      .done_o(done[2]), .prod_o(prod_v), .ovf_o(ovf[2]));

   function automatic bit isSigned(input int i);
      return i == 1;
   endfunction

   function automatic int outWidth(input int i);
      return (i == 0) ? 14 : 8;
   endfunction

   function automatic int iters(input int i);
      return (i == 0) ? 8 : 4;
   endfunction

   function automatic longint prodOf(input int i);
      case (i)
         0:       return longint'(prod_u);
         1:       return longint'($signed(prod_s));
         default: return longint'(prod_v);
      endcase
   endfunction

   // Reference: exact integer product, optional half-LSB bias, floor shift, clamp.
   function automatic exp_t model(input int i, input logic [13:0] a, input logic [7:0] b);
      exp_t   e;
      longint av, full, sh, lo, hi;
      av   = isSigned(i) ? longint'($signed(a)) : longint'(a);
      full = av * longint'(b);
      if (ROUND) full = full + (longint'(1) << (SHIFT - 1));
      sh = full >>> SHIFT;
      if (isSigned(i)) begin
         lo = -(longint'(1) << (outWidth(i) - 1));
         hi = (longint'(1) << (outWidth(i) - 1)) - 1;
      end else begin
         lo = 0;
         hi = (longint'(1) << outWidth(i)) - 1;
      end
      e.inst = i;
      e.p    = sh;
      e.o    = 1'b0;
      if (sh < lo) begin
         e.p = lo;
         e.o = 1'b1;
      end else if (sh > hi) begin
         e.p = hi;
         e.o = 1'b1;
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
               if (sb.size() == 0) begin
                  checkOutput($sformatf("spurious done[%0d]", i), longint'(done[i]), 0);
               end else begin
                  mon_e = sb.pop_front();
                  checkOutput("done instance", i, mon_e.inst);
                  checkOutput($sformatf("prod[%0d]", i), prodOf(i), mon_e.p);
                  checkOutput($sformatf("ovf[%0d]", i), longint'(ovf[i]), longint'(mon_e.o));
               end
            end
         end
      end
   end

   task automatic waitReady(input int i);
      int g;
      g = 0;
      while (ready[i] !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      checkOutput($sformatf("ready[%0d] before start", i), longint'(ready[i]), 1);
   endtask

   // Issues one start pulse; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(input int i, input logic [13:0] a, input logic [7:0] b, input bit push);
      waitReady(i);
      op_a[i]  = a;
      op_b[i]  = b;
      start[i] = 1'b1;
      if (push) sb.push_back(model(i, a, b));
      @(posedge clk);
      @(negedge clk);
      start[i] = 1'b0;
   endtask

   task automatic runTxn(input int i, input logic [13:0] a, input logic [7:0] b, input bit abort_idle);
      int lat, busy_cnt;
      abort[i] = abort_idle;
      applyStimulus(i, a, b, 1'b1);
      abort[i] = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      while (done[i] !== 1'b1 && lat < 50) begin
         if (busy[i] === 1'b1) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      checkOutput($sformatf("latency[%0d]", i), lat, iters(i));
      checkOutput($sformatf("busy cycles[%0d]", i), busy_cnt, iters(i));
      @(negedge clk);
      checkOutput($sformatf("done width[%0d]", i), longint'(done[i]), 0);
   endtask

   task automatic backToBack(input int i, input int n);
      int g;
      start[i] = 1'b1;
      for (int k = 0; k < n; k++) begin
         g = 0;
         while (ready[i] !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
         end
         if (k > 0) checkOutput($sformatf("b2b gap[%0d]", i), g, iters(i));
         op_a[i] = 14'($urandom);
         op_b[i] = 8'($urandom);
         sb.push_back(model(i, op_a[i], op_b[i]));
         @(posedge clk);
         @(negedge clk);
      end
      start[i] = 1'b0;
      g = 0;
      while (sb.size() != 0 && g < 50) begin
         @(negedge clk);
         g++;
      end
      checkOutput("b2b drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         abort[i] = 1'b0;
         op_a[i]  = '0;
         op_b[i]  = '0;
      end
      repeat (3) @(negedge clk);
      checkOutput("reset ready", longint'(ready[0]), 1);
      checkOutput("reset busy", longint'(busy[0]), 0);
      checkOutput("reset done", longint'(done[0]), 0);
      checkOutput("reset prod", prodOf(0), 0);
      checkOutput("reset ovf", longint'(ovf[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] default config directed");
      runTxn(0, 14'd1000, 8'd128, 1'b0);
      runTxn(0, 14'd1, 8'd128, 1'b0);
      runTxn(0, 14'd16383, 8'd255, 1'b1);
      runTxn(0, 14'd1000, 8'd128, 1'b0);

      $display("[TB] abort on third ITER cycle, ignored start while busy");
      applyStimulus(0, 14'd2, 8'd128, 1'b0);
      @(negedge clk);
      op_a[0]  = 14'd5;
      op_b[0]  = 8'd3;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      checkOutput("abort ready", longint'(ready[0]), 1);
      checkOutput("abort busy", longint'(busy[0]), 0);
      checkOutput("abort prod held", prodOf(0), 500);
      repeat (12) @(negedge clk);
      checkOutput("abort prod still held", prodOf(0), 500);
      checkOutput("abort ovf held", longint'(ovf[0]), 0);

      $display("[TB] default config random");
      for (int k = 0; k < 16; k++) runTxn(0, 14'($urandom), 8'($urandom), 1'b0);
      backToBack(0, 6);

      $display("[TB] signed 8-bit output, STEP=2");
      runTxn(1, 14'(-101), 8'd128, 1'b0);
      runTxn(1, 14'(-100), 8'd128, 1'b0);
      runTxn(1, 14'(-8192), 8'd255, 1'b0);
      runTxn(1, 14'd1000, 8'd128, 1'b0);
      runTxn(1, 14'd8191, 8'd255, 1'b0);
      for (int k = 0; k < 12; k++) runTxn(1, 14'($urandom), 8'($urandom), 1'b0);
      backToBack(1, 5);

      $display("[TB] unsigned 8-bit output, STEP=2");
      runTxn(2, 14'd16383, 8'd255, 1'b0);
      runTxn(2, 14'd1000, 8'd128, 1'b0);
      runTxn(2, 14'd300, 8'd128, 1'b0);
      for (int k = 0; k < 12; k++) runTxn(2, 14'($urandom), 8'($urandom_range(0, 40)), 1'b0);

      $display("[TB] reset mid-ITER");
      applyStimulus(2, 14'd1000, 8'd128, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mid reset ready", longint'(ready[2]), 1);
      checkOutput("mid reset busy", longint'(busy[2]), 0);
      checkOutput("mid reset done", longint'(done[2]), 0);
      checkOutput("mid reset prod", prodOf(2), 0);
      checkOutput("mid reset ovf", longint'(ovf[2]), 0);
      checkOutput("mid reset prod other", prodOf(0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      runTxn(2, 14'd300, 8'd128, 1'b0);

      repeat (4) @(negedge clk);
      checkOutput("scoreboard empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
